spi_target: RTL and testbench
=============================

SPI_TARGET -- requirements
Module: spi_target

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 8, giving the SPI word length in bits (legal range 4..32).
REQ-002 The module SHALL have parameter DEFAULT_TX, default all-zeros (DATA_WIDTH bits), giving the word shifted out when no TX word is buffered.
REQ-003 The module SHALL have port clock, input, 1, the single system clock; all logic is on its rising edge.
REQ-004 The module SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-005 The module SHALL have port sclk, input, 1, the SPI serial clock from the controller, asynchronous to clock.
REQ-006 The module SHALL have port cs, input, 1, the active-low chip select, asynchronous to clock.
REQ-007 The module SHALL have port pico, input, 1, the controller-to-target serial data.
REQ-008 The module SHALL have port poci, output, 1, the target-to-controller serial data.
REQ-009 The module SHALL have port poci_oe, output, 1, the poci output enable; the board top builds the tristate from it.
REQ-010 The module SHALL have ports tx_data (input, DATA_WIDTH), tx_valid (input, 1) and tx_ready (output, 1), a valid/ready TX word handshake.
REQ-011 The module SHALL have ports rx_data (output, DATA_WIDTH) and rx_valid (output, 1), the received word and its 1-cycle strobe.
REQ-012 The module SHALL have ports busy (output, 1) and tx_underrun (output, 1), the transaction-active flag and the 1-cycle no-TX-word strobe.

Function
REQ-013 The module SHALL operate in SPI mode 0 only: CPOL=0, CPHA=0, MSB first.
REQ-014 sclk, cs and pico SHALL each pass a 2-flop synchronizer plus a history flop; edges SHALL be detected from synchronized stage 2 versus stage 3.
REQ-015 Every pin event SHALL take effect on the 3rd clock edge after the pin transition, a fixed latency; sclk frequency SHALL be at most clock/8.
REQ-016 The module SHALL be in state IDLE while synchronized cs=1, and in state ACTIVE from a detected cs fall until a detected cs rise; busy=1 exactly in ACTIVE.
REQ-017 poci_oe SHALL equal the inverse of synchronized cs.
REQ-018 At word start (cs fall, or the sclk rise completing a word), the TX shift register SHALL load the buffered word if present, emptying the buffer; otherwise it SHALL load DEFAULT_TX and pulse tx_underrun for 1 cycle.
REQ-019 poci SHALL present the shift register MSB; on each sclk fall in ACTIVE the shift register SHALL shift left by one.
REQ-020 On each sclk rise in ACTIVE, pico (synchronized) SHALL shift into the RX register LSB and a bit counter (0..DATA_WIDTH-1) SHALL increment.
REQ-021 When the counter wraps from DATA_WIDTH-1 to 0, rx_data SHALL update to the completed word and rx_valid SHALL pulse 1 cycle; rx_data holds until the next completed word.
REQ-022 The TX buffer SHALL be one entry; tx_ready=1 iff the buffer is empty; tx_valid&&tx_ready SHALL load tx_data into the buffer.
REQ-023 If a handshake and a word-start load occur in the same cycle with the buffer empty, the load SHALL use DEFAULT_TX (and pulse tx_underrun) and the buffer SHALL become full with the new word.
REQ-024 A cs rise mid-word SHALL discard the partial word: no rx_valid, counter cleared, buffered TX word retained.
REQ-025 sclk edges while IDLE SHALL be ignored.
REQ-026 A cs fall and an sclk edge detected in the same cycle SHALL be treated as the cs fall only.
REQ-027 rx_valid SHALL pulse regardless of software consumption; there SHALL be no RX backpressure.

Reset
REQ-028 Reset SHALL force poci=0, poci_oe=0, tx_ready=1, rx_data=0, rx_valid=0, busy=0 and tx_underrun=0.
REQ-029 Reset SHALL empty the TX buffer, clear the counter and shift registers, and preset synchronizers to sclk=0, cs=1, pico=0; reset mid-transaction SHALL return to IDLE with no strobes.

Structure
REQ-030 SPI mode and bit-order constants SHALL live in a shared package, spi_pkg, for reuse by the controller side.
REQ-031 The sub-module spi_pin_sync (2-flop synchronizer plus history flop, with rise/fall outputs) SHALL be used, instanced three times.

Verification
REQ-032 With 0xA5 buffered, the controller sends 0x3C at clock/8 -> poci bits 1,0,1,0,0,1,0,1; rx_data=0x3C with one rx_valid pulse; tx_ready=1 after the cs fall.
REQ-033 With the buffer empty, a transfer runs -> poci sends DEFAULT_TX, tx_underrun pulses once, and rx_valid still pulses.
REQ-034 Two words 0x11, 0x22 are sent under one cs with 0x55 then 0x66 buffered between them -> rx_valid twice with 0x11 then 0x22, and poci sends 0x55 then 0x66.
REQ-035 cs rises after 5 bits -> no rx_valid, busy falls 3 cycles after the cs pin rise, and the next full transfer receives correctly.
REQ-036 reset is asserted after bit 3 -> all outputs are at reset values the next cycle, the buffer is empty, and a subsequent transfer is clean.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI definitions: mode/bit-order constants, target FSM states and
// synchronizer reset levels, reusable by controller and target blocks.
package spi_pkg;

    localparam logic SPI_CPOL      = 1'b0;
    localparam logic SPI_CPHA      = 1'b0;
    localparam logic SPI_MSB_FIRST = 1'b1;

    // Idle pin levels the synchronizers are preset to.
    localparam logic SYNC_SCLK_RST = 1'b0;
    localparam logic SYNC_CS_RST   = 1'b1;
    localparam logic SYNC_PICO_RST = 1'b0;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } spi_state_e;

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchronizer plus history flop for one asynchronous pin; edges are
// taken between stage 2 and stage 3 so they act on the third clock edge.
module spi_pin_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    // Synchronizer chain with history stage.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_s1 <= RST_VAL;
            r_s2 <= RST_VAL;
            r_s3 <= RST_VAL;
        end else begin
            r_s1 <= i_pin;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_level = r_s2;
    assign o_rise  = r_s2 & ~r_s3;
    assign o_fall  = ~r_s2 & r_s3;

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target, MSB first, with a one-entry TX buffer and an RX word strobe.
// All SPI pins are oversampled in the system clock domain.
module spi_target
    import spi_pkg::*;
#(
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_TX = {DATA_WIDTH{1'b0}}
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  sclk,
    input  logic                  cs,
    input  logic                  pico,
    output logic                  poci,
    output logic                  poci_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  tx_underrun
);

    localparam int            CW       = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

    spi_state_e r_state;
    spi_state_e w_state_nxt;
    logic       w_busy;

    logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
    logic w_cs_lvl, w_cs_rise, w_cs_fall;
    logic w_pico_lvl, w_pico_rise, w_pico_fall;
    logic w_unused_pico_edges;

    logic [CW-1:0]         r_cnt;
    logic [DATA_WIDTH-2:0] r_rx_shift;
    logic [DATA_WIDTH-1:0] r_tx_shift;
    logic [DATA_WIDTH-1:0] r_rx_data;
    logic [DATA_WIDTH-1:0] r_buf;
    logic                  r_buf_full;
    logic                  r_rx_valid;
    logic                  r_tx_underrun;
    logic                  r_poci_oe;

    logic w_act, w_bit_rise, w_bit_fall, w_word_done, w_word_start, w_hs;

    spi_pin_sync #(.RST_VAL(SYNC_SCLK_RST)) u_sync_sclk (
        .i_clock(clock), .i_reset(reset), .i_pin(sclk),
        .o_level(w_sclk_lvl), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );
    spi_pin_sync #(.RST_VAL(SYNC_CS_RST)) u_sync_cs (
        .i_clock(clock), .i_reset(reset), .i_pin(cs),
        .o_level(w_cs_lvl), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );
    spi_pin_sync #(.RST_VAL(SYNC_PICO_RST)) u_sync_pico (
        .i_clock(clock), .i_reset(reset), .i_pin(pico),
        .o_level(w_pico_lvl), .o_rise(w_pico_rise), .o_fall(w_pico_fall)
    );

    // Only the sampled pico level matters; sclk level is implied by its edges.
    assign w_unused_pico_edges = w_pico_rise ^ w_pico_fall ^ w_sclk_lvl;

    // Edges only count inside a transaction; a same-cycle cs rise wins.
    assign w_act        = (r_state == ST_ACTIVE);
    assign w_bit_rise   = w_act & w_sclk_rise & ~w_cs_rise;
    assign w_bit_fall   = w_act & w_sclk_fall & ~w_cs_rise;
    assign w_word_done  = w_bit_rise & (r_cnt == CNT_LAST);
    assign w_word_start = (~w_act & w_cs_fall) | w_word_done;
    assign w_hs         = tx_valid & ~r_buf_full;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_cs_fall) w_state_nxt = ST_ACTIVE;
                else           w_state_nxt = ST_IDLE;
            end
            ST_ACTIVE: begin
                if (w_cs_rise) w_state_nxt = ST_IDLE;
                else           w_state_nxt = ST_ACTIVE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        w_busy = 1'b0;
        case (r_state)
            ST_ACTIVE: w_busy = 1'b1;
            ST_IDLE:   w_busy = 1'b0;
            default:   w_busy = 1'b0;
        endcase
    end

    // Shift registers, bit counter, TX buffer and strobes.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt         <= CW'(0);
            r_rx_shift    <= {(DATA_WIDTH-1){1'b0}};
            r_tx_shift    <= {DATA_WIDTH{1'b0}};
            r_rx_data     <= {DATA_WIDTH{1'b0}};
            r_buf         <= {DATA_WIDTH{1'b0}};
            r_buf_full    <= 1'b0;
            r_rx_valid    <= 1'b0;
            r_tx_underrun <= 1'b0;
            r_poci_oe     <= 1'b0;
        end else begin
            r_rx_valid    <= w_word_done;
            r_tx_underrun <= w_word_start & ~r_buf_full;
            r_poci_oe     <= ~w_cs_lvl;
            if (w_act && w_cs_rise) begin
                r_cnt <= CW'(0);
            end else if (w_bit_rise) begin
                r_rx_shift <= {r_rx_shift[DATA_WIDTH-3:0], w_pico_lvl};
                if (w_word_done) begin
                    r_cnt     <= CW'(0);
                    r_rx_data <= {r_rx_shift, w_pico_lvl};
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
            // The fall right after a word-completing rise must not shift out
            // the freshly loaded MSB; the counter is back at zero there.
            if (w_word_start) begin
                r_tx_shift <= r_buf_full ? r_buf : DEFAULT_TX;
            end else if (w_bit_fall && (r_cnt != CW'(0))) begin
                r_tx_shift <= {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
            end
            if (w_hs) begin
                r_buf      <= tx_data;
                r_buf_full <= 1'b1;
            end else if (w_word_start) begin
                r_buf_full <= 1'b0;
            end
        end
    end

    assign poci        = r_tx_shift[DATA_WIDTH-1];
    assign poci_oe     = r_poci_oe;
    assign tx_ready    = ~r_buf_full;
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign busy        = w_busy;
    assign tx_underrun = r_tx_underrun;

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: drives SPI pins at clock/8 and scoreboards
// received words, with direct checks on handshake, strobes and reset.
module tb_spi_target;

    localparam int         W      = 8;
    localparam logic [7:0] DEF_TX = 8'hC3;

    logic         clock = 1'b0;
    logic         reset, sclk, cs, pico, tx_valid;
    logic [W-1:0] tx_data;
    logic         poci, poci_oe, tx_ready, rx_valid, busy, tx_underrun;
    logic [W-1:0] rx_data;

    int n_vec = 0;
    int n_err = 0;
    int n_rxv = 0;
    int n_unf = 0;
    int r0, u0;
    logic [W-1:0] rx_q[$];

    spi_target #(.DATA_WIDTH(W), .DEFAULT_TX(DEF_TX)) dut (
        .clock(clock), .reset(reset), .sclk(sclk), .cs(cs), .pico(pico),
        .poci(poci), .poci_oe(poci_oe), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .busy(busy), .tx_underrun(tx_underrun)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Monitor: scoreboard received words and count strobes.
    always @(negedge clock) begin
        if (rx_valid === 1'b1) begin
            n_rxv++;
            if (rx_q.size() == 0) begin
                n_vec++;
                n_err++;
                $error("FAIL rx_unexpected observed=%h expected=none", rx_data);
            end else begin
                check("rx_data", rx_data, rx_q.pop_front());
            end
        end
        if (tx_underrun === 1'b1) n_unf++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic push_tx(input logic [W-1:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        wait_clk(1);
        tx_valid = 1'b0;
    endtask

    task automatic cs_low();
        cs = 1'b0;
        wait_clk(8);
    endtask

    task automatic cs_high();
        cs = 1'b1;
        wait_clk(8);
    endtask

    // Controller side of one word: poci sampled at each sclk rise.
    task automatic xfer(input logic [W-1:0] mosi, input logic [W-1:0] exp_miso, input int nbits);
        logic [W-1:0] got;
        got = '0;
        if (nbits == W) rx_q.push_back(mosi);
        for (int i = 0; i < nbits; i++) begin
            pico = mosi[W-1-i];
            wait_clk(4);
            got  = {got[W-2:0], poci};
            sclk = 1'b1;
            wait_clk(4);
            sclk = 1'b0;
        end
        wait_clk(4);
        if (nbits == W) check("poci_word", got, exp_miso);
    endtask

    initial begin
        reset = 1'b1; sclk = 1'b0; cs = 1'b1; pico = 1'b0;
        tx_valid = 1'b0; tx_data = '0;
        wait_clk(3);
        check("rst_poci", poci, 1'b0);
        check("rst_poci_oe", poci_oe, 1'b0);
        check("rst_tx_ready", tx_ready, 1'b1);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_underrun", tx_underrun, 1'b0);
        reset = 1'b0;
        wait_clk(4);

        // Buffered A5 out while 3C comes in.
        r0 = n_rxv;
        push_tx(8'hA5);
        check("buf_full_ready", tx_ready, 1'b0);
        cs_low();
        check("cs_fall_busy", busy, 1'b1);
        check("cs_fall_ready", tx_ready, 1'b1);
        check("cs_fall_oe", poci_oe, 1'b1);
        xfer(8'h3C, 8'hA5, 8);
        cs_high();
        check("idle_busy", busy, 1'b0);
        check("idle_oe", poci_oe, 1'b0);
        check("rx_hold_3c", rx_data, 8'h3C);
        check("rxv_count_1", n_rxv - r0, 1);

        // Empty buffer at cs fall, with a handshake in the same cycle.
        r0 = n_rxv; u0 = n_unf;
        cs = 1'b0;
        wait_clk(2);
        tx_data = 8'h5A; tx_valid = 1'b1;
        wait_clk(1);
        tx_valid = 1'b0;
        check("hs_at_start_full", tx_ready, 1'b0);
        wait_clk(5);
        xfer(8'h96, DEF_TX, 8);
        check("underrun_once", n_unf - u0, 1);
        check("rxv_count_2", n_rxv - r0, 1);
        check("buf_consumed", tx_ready, 1'b1);
        cs_high();

        // Two back-to-back words under one cs.
        r0 = n_rxv;
        push_tx(8'h55);
        cs_low();
        push_tx(8'h66);
        xfer(8'h11, 8'h55, 8);
        xfer(8'h22, 8'h66, 8);
        check("rxv_count_3", n_rxv - r0, 2);
        check("rx_hold_22", rx_data, 8'h22);
        cs_high();

        // Abort after 5 bits; buffered word survives.
        r0 = n_rxv;
        cs_low();
        push_tx(8'h88);
        xfer(8'hF0, 8'h00, 5);
        cs = 1'b1;
        wait_clk(2);
        check("abort_busy_2", busy, 1'b1);
        wait_clk(1);
        check("abort_busy_3", busy, 1'b0);
        wait_clk(5);
        check("abort_no_rxv", n_rxv - r0, 0);
        check("abort_buf_kept", tx_ready, 1'b0);
        cs_low();
        xfer(8'hE7, 8'h88, 8);
        cs_high();
        check("after_abort_rxv", n_rxv - r0, 1);

        // Reset mid-transfer, idle sclk noise, then a clean transfer.
        cs_low();
        push_tx(8'h99);
        xfer(8'hAA, 8'h00, 3);
        reset = 1'b1; cs = 1'b1;
        wait_clk(1);
        check("mid_rst_poci", poci, 1'b0);
        check("mid_rst_oe", poci_oe, 1'b0);
        check("mid_rst_ready", tx_ready, 1'b1);
        check("mid_rst_rx_data", rx_data, 8'h00);
        check("mid_rst_rx_valid", rx_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_underrun", tx_underrun, 1'b0);
        reset = 1'b0;
        wait_clk(8);
        repeat (3) begin
            sclk = 1'b1; wait_clk(4);
            sclk = 1'b0; wait_clk(4);
        end
        check("idle_sclk_busy", busy, 1'b0);
        push_tx(8'h42);
        cs_low();
        xfer(8'hBD, 8'h42, 8);
        cs_high();
        check("post_rst_rx", rx_data, 8'hBD);
        check("scoreboard_empty", rx_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
